// File: rtl/hit_pkg.sv
// hit_pkg: shared types and defaults for the hit serializer block.
package hit_pkg;

  localparam int VAL_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef logic [VAL_W_DEF-1:0] value_t;

endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: small synchronous FIFO with first-word-fall-through read data.
// A read and a write in the same cycle are legal even when full.
// flush empties the FIFO at the clock edge and overrides any read or write.
module hit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage next-state; a pop frees the slot a simultaneous push uses.
  always_comb begin
    do_rd    = rd_en && !empty && !flush;
    do_wr    = wr_en && (!full || do_rd) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hit_serializer.sv
// hit_serializer: buffers brick-destroyed events and replays each point value
// as a train of single-cycle hit pulses for the score counter.
// Optional feature macro: HIT_SERIALIZER_COMBO_EN (combo bonus of +1 point for
// an event accepted within COMBO_WIN cycles of the previous accepted event).
//
// state | meaning
// IDLE  | waiting; pops the FIFO head when one is available
// PULSE | emitting one pulse (hit goes high on the following cycle)
// GAP   | forced-low spacing between pulses of the same train
module hit_serializer
  import hit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int VAL_W     = VAL_W_DEF,
  parameter int PULSE_GAP = 1,
  parameter int COMBO_WIN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restartGame,
  input  logic             brickHit,
  input  logic [VAL_W-1:0] brickValue,
  output logic             hit,
  output logic             busy,
  output logic             overflow
);

  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               hit_q, hit_d;
  logic               ovf_q, ovf_d;

  logic               pop;
  logic               wr_en;
  logic               event_valid;
  logic [VAL_W-1:0]   wr_data;
  logic [VAL_W-1:0]   rd_data;
  logic               fifo_full;
  logic               fifo_empty;

  hit_fifo #(
    .DEPTH (DEPTH),
    .W     (VAL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (restartGame),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Train sequencing, enqueue acceptance and overflow detection; restart overrides all.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rem_d   = rd_data;
          state_d = PULSE;
        end
      end
      PULSE: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == {{(VAL_W-1){1'b0}}, 1'b1}) begin
          state_d = IDLE;
        end else if (PULSE_GAP > 0) begin
          state_d = GAP;
          gap_d   = GAP_W'(PULSE_GAP - 1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = PULSE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    hit_d       = (state_q == PULSE);
    event_valid = brickHit && (brickValue != '0);
    wr_en       = event_valid && (!fifo_full || pop);
    if (event_valid && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end

    if (restartGame) begin
      state_d = IDLE;
      rem_d   = '0;
      gap_d   = '0;
      ovf_d   = 1'b0;
      hit_d   = 1'b0;
      pop     = 1'b0;
      wr_en   = 1'b0;
    end
  end

  // FSM and output registers; reset aborts any train immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef HIT_SERIALIZER_COMBO_EN
  localparam int CW = $clog2(COMBO_WIN + 1);

  logic [CW-1:0] combo_cnt_q, combo_cnt_d;
  logic          combo_arm_q, combo_arm_d;
  logic          bonus;

  // Combo timer: saturating count since the last accepted event; first event after reset/restart is unarmed.
  always_comb begin
    bonus       = combo_arm_q && (combo_cnt_q < CW'(COMBO_WIN));
    combo_cnt_d = combo_cnt_q;
    combo_arm_d = combo_arm_q;
    if (combo_cnt_q < CW'(COMBO_WIN)) begin
      combo_cnt_d = combo_cnt_q + 1'b1;
    end
    if (wr_en) begin
      combo_cnt_d = '0;
      combo_arm_d = 1'b1;
    end
    if (restartGame) begin
      combo_cnt_d = '0;
      combo_arm_d = 1'b0;
    end
    wr_data = brickValue;
    if (bonus && (brickValue != '1)) begin
      wr_data = brickValue + 1'b1;
    end
  end

  // Combo timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      combo_cnt_q <= '0;
      combo_arm_q <= 1'b0;
    end else begin
      combo_cnt_q <= combo_cnt_d;
      combo_arm_q <= combo_arm_d;
    end
  end
`else
  logic unused_combo_win;
  assign unused_combo_win = ^COMBO_WIN;

  // Without the combo feature, values go into the FIFO unmodified.
  always_comb begin
    wr_data = brickValue;
  end
`endif

  assign hit      = hit_q;
  assign overflow = ovf_q;
  assign busy     = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_hit_serializer.sv
// Scoreboard bench for hit_serializer: stimulus pushes the expected cycle of
// every hit pulse; a negedge monitor pops and compares on each observed pulse.
module tb_hit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       restartGame;
  logic       brickHit;
  logic [3:0] brickValue;
  logic       hit;
  logic       busy;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hits_seen = 0;
  int sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hit_serializer #(
    .DEPTH     (4),
    .VAL_W     (4),
    .PULSE_GAP (1),
    .COMBO_WIN (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .restartGame (restartGame),
    .brickHit    (brickHit),
    .brickValue  (brickValue),
    .hit         (hit),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed pulse must match the next expected pulse cycle.
  always @(negedge clk) begin
    if (!reset && hit) begin
      int e;
      hits_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_hit: got hit at cyc %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL hit_time: got cyc %0d expected cyc %0d", cyc, e);
        end
      end
    end
  end

  task automatic sync_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Present a 1-cycle strobe sampled at edge e; returns at the negedge after e.
  task automatic strobe(input int e, input int v);
    sync_to(e - 1);
    brickHit   = 1'b1;
    brickValue = 4'(v);
    @(negedge clk);
    brickHit   = 1'b0;
    brickValue = 4'd0;
  endtask

  initial begin
    int e0;
    int h0;
    reset       = 1'b1;
    restartGame = 1'b0;
    brickHit    = 1'b0;
    brickValue  = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_hit", int'(hit), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(overflow), 0);

    // Single event, value 3.
    e0 = cyc + 2;
    h0 = hits_seen;
    sb.push_back(e0 + 2); sb.push_back(e0 + 4); sb.push_back(e0 + 6);
    strobe(e0, 3);
    sync_to(e0 + 1);
    check("single_busy_active", int'(busy), 1);
    sync_to(e0 + 6);
    check("single_busy_after", int'(busy), 0);
    sync_to(e0 + 8);
    check("single_count", hits_seen - h0, 3);
    check("single_pending", sb.size(), 0);

    // Zero-valued strobe is ignored.
    e0 = cyc + 2;
    h0 = hits_seen;
    strobe(e0, 0);
    check("zero_busy", int'(busy), 0);
    sync_to(e0 + 5);
    check("zero_busy_late", int'(busy), 0);
    check("zero_overflow", int'(overflow), 0);
    check("zero_count", hits_seen - h0, 0);

    // Overflow: one train running, then five back-to-back value-15 strobes.
    e0 = cyc + 2;
    h0 = hits_seen;
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 15; k++)
        sb.push_back(e0 + 2 + 30 * j + 2 * k);
    strobe(e0, 15);
    for (int i = 0; i < 4; i++) strobe(e0 + 3 + i, 15);
    check("ovf_before_drop", int'(overflow), 0);
    strobe(e0 + 7, 15);
    check("ovf_on_drop", int'(overflow), 1);
    sync_to(e0 + 152);
    check("ovf_busy_after", int'(busy), 0);
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_count", hits_seen - h0, 75);
    check("ovf_pending", sb.size(), 0);

    // Restart during pulse 2 of a value-5 train with two events queued.
    e0 = cyc + 2;
    h0 = hits_seen;
    sb.push_back(e0 + 2); sb.push_back(e0 + 4);
    strobe(e0, 5);
    strobe(e0 + 1, 3);
    strobe(e0 + 2, 3);
    sync_to(e0 + 4);
    restartGame = 1'b1;
    brickHit    = 1'b1;
    brickValue  = 4'd7;
    @(negedge clk);
    restartGame = 1'b0;
    brickHit    = 1'b0;
    brickValue  = 4'd0;
    check("restart_hit", int'(hit), 0);
    check("restart_busy", int'(busy), 0);
    check("restart_overflow", int'(overflow), 0);
    sync_to(e0 + 40);
    check("restart_busy_late", int'(busy), 0);
    check("restart_count", hits_seen - h0, 2);
    check("restart_pending", sb.size(), 0);

    // Full FIFO with a pop at the same edge accepts the write; the next one drops.
    e0 = cyc + 2;
    sb.push_back(e0 + 2); sb.push_back(e0 + 4);
    for (int k = 0; k < 5; k++) sb.push_back(e0 + 6 + 2 * k);
    strobe(e0, 2);
    for (int i = 1; i <= 5; i++) strobe(e0 + i, 1);
    check("full_pop_no_ovf", int'(overflow), 0);
    strobe(e0 + 6, 1);
    check("full_drop_ovf", int'(overflow), 1);

    // Asynchronous reset in the middle of that train.
    sync_to(e0 + 8);
    check("pre_reset_hit", int'(hit), 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_hit", int'(hit), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_overflow", int'(overflow), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    h0 = hits_seen;
    @(negedge clk);
    check("post_reset_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("post_reset_hits", hits_seen - h0, 0);

    // Combo window: events value 2 at t, t+10, t+40.
    e0 = cyc + 2;
    h0 = hits_seen;
    sb.push_back(e0 + 2); sb.push_back(e0 + 4);
    sb.push_back(e0 + 12); sb.push_back(e0 + 14);
`ifdef HIT_SERIALIZER_COMBO_EN
    sb.push_back(e0 + 16);
`endif
    sb.push_back(e0 + 42); sb.push_back(e0 + 44);
    strobe(e0, 2);
    strobe(e0 + 10, 2);
    strobe(e0 + 40, 2);
    sync_to(e0 + 50);
`ifdef HIT_SERIALIZER_COMBO_EN
    check("combo_count", hits_seen - h0, 7);
`else
    check("combo_count", hits_seen - h0, 6);
`endif
    check("combo_pending", sb.size(), 0);
    check("combo_busy_after", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
